vta_mem_arbiter: RTL and testbench
==================================

# vta_mem_arbiter

Shares one VTAMemDPI memory port among NUM_CLIENTS requesters, one burst transaction at a time. Sits between the accelerator load/store engines and the DPI memory model. Arbitrates requests, issues a single-cycle DPI request, then steers write beats from, or read beats to, the granted client until the burst completes.

## Interface
- NUM_CLIENTS, 2, requesters sharing the port (2..8)
- LEN_BITS, 8, burst length field width; beats = len+1
- ADDR_BITS, 64, address width
- DATA_BITS, 64, data beat width
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cl_req_valid  in  N  per-client request valid
- cl_req_ready  out  N  per-client request accept
- cl_req_opcode  in  N  per-client opcode: 0 read, 1 write
- cl_req_len  in  N*LEN_BITS  per-client burst length minus one
- cl_req_addr  in  N*ADDR_BITS  per-client byte address
- cl_wr_valid  in  N  per-client write beat valid
- cl_wr_ready  out  N  per-client write beat accept
- cl_wr_bits  in  N*DATA_BITS  per-client write data
- cl_rd_valid  out  N  per-client read beat valid
- cl_rd_ready  in  N  per-client read beat accept
- cl_rd_bits  out  DATA_BITS  read data, shared, valid for the granted client only
- dpi_req_valid, dpi_req_opcode  out  1 each  DPI request
- dpi_req_len  out  LEN_BITS; dpi_req_addr  out  ADDR_BITS
- dpi_wr_valid  out  1; dpi_wr_bits  out  DATA_BITS
- dpi_rd_valid  in  1; dpi_rd_bits  in  DATA_BITS; dpi_rd_ready  out  1
- busy  out  1  transaction in flight (state != IDLE)
- grant_id  out  $clog2(N)  currently granted client

## Operation
- FSM states: IDLE, ISSUE, WDATA, RDATA.
- IDLE:
  - The arbiter picks a winner among cl_req_valid, round-robin starting at rr_ptr.
  - cl_req_ready[winner]=1 combinationally.
  - On the handshake, latch opcode/len/addr and grant_id. Set rr_ptr=(winner+1) mod N. Go to ISSUE.
  - With no valid request, stay in IDLE with all readies low.
- ISSUE:
  - dpi_req_valid=1 for exactly one cycle with the latched fields.
  - Load beat counter = len+1. The counter is LEN_BITS+1 wide, so len=all-ones gives 2^LEN_BITS beats with no wrap.
  - Next state: WDATA if opcode=1, else RDATA.
- WDATA:
  - cl_wr_ready[g]=1, dpi_wr_valid=cl_wr_valid[g], dpi_wr_bits=cl_wr_bits[g].
  - Decrement the counter per valid beat. Client wr_valid bubbles are allowed.
  - On the last beat, return to IDLE.
- RDATA:
  - cl_rd_valid[g]=dpi_rd_valid, cl_rd_bits=dpi_rd_bits, dpi_rd_ready=cl_rd_ready[g].
  - Decrement on dpi_rd_valid & cl_rd_ready[g]. On the last beat, return to IDLE.
- Non-granted clients always see ready/valid low.
- cl_wr_valid from non-granted clients is ignored. Non-granted clients may hold cl_req_valid across any number of transactions.
- A client must keep request fields stable while cl_req_valid=1 and not yet accepted.

## Timing
- Reset (async assert, release synchronous to clock):
  - state=IDLE, rr_ptr=0, counter=0.
  - All outputs 0: dpi_*, cl_*_ready, cl_rd_valid, busy, grant_id.
  - Reset mid-burst abandons the transaction; no further beats are driven.
- Latency, request handshake to dpi_req_valid: 1 cycle.
- Minimum transaction (len=0) occupancy: IDLE, ISSUE, one data cycle. The next grant can occur the cycle after the last beat.
- Simultaneous requests: exactly one grant per IDLE cycle.
- A client requesting again immediately after its own grant waits behind any other valid requester.
- Read beats pass through combinationally, so no added latency. The DPI model itself delays read data one cycle.

## Configuration
- MEM_ARB_PRIO_EN defined: client 0 has fixed highest priority, and clients 1..N-1 are round-robin among themselves when client 0 is idle.
- Undefined: pure round-robin across all clients.
- The FSM and datapath are identical in both builds.

## Structure
- Package vta_mem_arb_pkg holds:
  - state enum {IDLE, ISSUE, WDATA, RDATA}
  - opcode constants OP_RD=0, OP_WR=1
- Sub-module vta_rr_arbiter: N-bit request vector plus pointer in, one-hot grant plus index out, purely combinational. Honors MEM_ARB_PRIO_EN.

## Test plan
- Single read, client 0, len=3, addr=0x1000 -> one dpi_req_valid pulse, opcode=0, len=3; exactly 4 beats to cl_rd_valid[0]; busy low afterward.
- Write from client 1, len=0, data 0xDEADBEEF -> dpi_wr_valid for one cycle carrying 0xDEADBEEF; cl_wr_ready[0] never asserted.
- Clients 0 and 1 both request continuously (no macro) -> grant_id sequence 0,1,0,1; with MEM_ARB_PRIO_EN -> always 0.
- Read with cl_rd_ready[0] toggling 1,0,1,0, len=1 -> dpi_rd_ready mirrors it; transaction ends only after 2 accepted beats.
- len=255 write -> 256 beats counted; FSM returns to IDLE with no counter wrap.
- reset driven low in RDATA mid-burst -> all outputs 0 immediately, state IDLE; new request accepted after release.

Source files
------------

// File: rtl/vta_mem_arbiter_pkg.sv
// vta_mem_arb_pkg: shared FSM state encoding and opcode constants for the memory arbiter.
package vta_mem_arb_pkg;
   typedef enum logic [1:0] {IDLE, ISSUE, WDATA, RDATA} state_e;
   localparam logic OP_RD = 1'b0;
   localparam logic OP_WR = 1'b1;
endpackage

// File: rtl/vta_mem_arbiter_if.sv
// vta_mem_arbiter_if: client request/data bundle plus the DPI memory port; slave = arbiter, master = clients and memory.
interface vta_mem_arbiter_if #(
   parameter int NUM_CLIENTS = 2,
   parameter int LEN_BITS    = 8,
   parameter int ADDR_BITS   = 64,
   parameter int DATA_BITS   = 64
);
   logic [NUM_CLIENTS-1:0]           cl_req_valid, cl_req_ready, cl_req_opcode;
   logic [NUM_CLIENTS*LEN_BITS-1:0]  cl_req_len;
   logic [NUM_CLIENTS*ADDR_BITS-1:0] cl_req_addr;
   logic [NUM_CLIENTS-1:0]           cl_wr_valid, cl_wr_ready;
   logic [NUM_CLIENTS*DATA_BITS-1:0] cl_wr_bits;
   logic [NUM_CLIENTS-1:0]           cl_rd_valid, cl_rd_ready;
   logic [DATA_BITS-1:0]             cl_rd_bits;
   logic                             dpi_req_valid, dpi_req_opcode;
   logic [LEN_BITS-1:0]              dpi_req_len;
   logic [ADDR_BITS-1:0]             dpi_req_addr;
   logic                             dpi_wr_valid;
   logic [DATA_BITS-1:0]             dpi_wr_bits;
   logic                             dpi_rd_valid, dpi_rd_ready;
   logic [DATA_BITS-1:0]             dpi_rd_bits;
   modport slave (
      input  cl_req_valid, cl_req_opcode, cl_req_len, cl_req_addr, cl_wr_valid, cl_wr_bits, cl_rd_ready,
      output cl_req_ready, cl_wr_ready, cl_rd_valid, cl_rd_bits,
      output dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr, dpi_wr_valid, dpi_wr_bits, dpi_rd_ready,
      input  dpi_rd_valid, dpi_rd_bits
   );
   modport master (
      output cl_req_valid, cl_req_opcode, cl_req_len, cl_req_addr, cl_wr_valid, cl_wr_bits, cl_rd_ready,
      input  cl_req_ready, cl_wr_ready, cl_rd_valid, cl_rd_bits,
      input  dpi_req_valid, dpi_req_opcode, dpi_req_len, dpi_req_addr, dpi_wr_valid, dpi_wr_bits, dpi_rd_ready,
      output dpi_rd_valid, dpi_rd_bits
   );
endinterface

// File: rtl/vta_rr_arbiter.sv
// vta_rr_arbiter: combinational round-robin pick starting at ptr_i.
// MEM_ARB_PRIO_EN gives client 0 fixed top priority; the rest stay round-robin.
module vta_rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o
);
   logic [IW-1:0] k;
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      k     = '0;
`ifdef MEM_ARB_PRIO_EN
      if (req_i[0]) gnt_o[0] = 1'b1;
`endif
      for (int i = 0; i < N; i++) begin
         k = IW'((int'(ptr_i) + i) % N);
         if (gnt_o == '0 && req_i[k]) begin
            gnt_o[k] = 1'b1;
            idx_o    = k;
         end
      end
   end
endmodule

// File: rtl/vta_mem_arbiter.sv
// vta_mem_arbiter: shares one DPI memory port among NUM_CLIENTS burst requesters, one transaction at a time.
// Build option MEM_ARB_PRIO_EN (in vta_rr_arbiter) makes client 0 highest priority.
module vta_mem_arbiter
   import vta_mem_arb_pkg::*;
#(
   parameter int NUM_CLIENTS = 2,
   parameter int LEN_BITS    = 8,
   parameter int ADDR_BITS   = 64,
   parameter int DATA_BITS   = 64
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   vta_mem_arbiter_if.slave               bus,
   output logic                           busy_o,
   output logic [$clog2(NUM_CLIENTS)-1:0] grant_id_o
);
   localparam int IW = $clog2(NUM_CLIENTS);
   localparam int CW = LEN_BITS + 1;
   state_e               state_q, state_d;
   logic [IW-1:0]        gnt_q, gnt_d, rr_q, rr_d, win_idx;
   logic [NUM_CLIENTS-1:0] win_oh;
   logic                 op_q, op_d, beat;
   logic [LEN_BITS-1:0]  len_q, len_d;
   logic [ADDR_BITS-1:0] addr_q, addr_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   vta_rr_arbiter #(.N(NUM_CLIENTS), .IW(IW)) u_arb (
      .req_i(bus.cl_req_valid), .ptr_i(rr_q), .gnt_o(win_oh), .idx_o(win_idx)
   );

   always_comb begin
      state_d            = state_q;
      gnt_d              = gnt_q;
      rr_d               = rr_q;
      op_d               = op_q;
      len_d              = len_q;
      addr_d             = addr_q;
      cnt_d              = cnt_q;
      beat               = 1'b0;
      bus.cl_req_ready   = '0;
      bus.cl_wr_ready    = '0;
      bus.cl_rd_valid    = '0;
      bus.cl_rd_bits     = '0;
      bus.dpi_req_valid  = 1'b0;
      bus.dpi_req_opcode = 1'b0;
      bus.dpi_req_len    = '0;
      bus.dpi_req_addr   = '0;
      bus.dpi_wr_valid   = 1'b0;
      bus.dpi_wr_bits    = '0;
      bus.dpi_rd_ready   = 1'b0;
      case (state_q)
         IDLE: begin
            // readies stay low while reset is held, even with requests pending
            if (rst_ni && |bus.cl_req_valid) begin
               bus.cl_req_ready = win_oh;
               gnt_d            = win_idx;
               op_d             = bus.cl_req_opcode[win_idx];
               len_d            = bus.cl_req_len[win_idx*LEN_BITS +: LEN_BITS];
               addr_d           = bus.cl_req_addr[win_idx*ADDR_BITS +: ADDR_BITS];
               rr_d             = IW'((int'(win_idx) + 1) % NUM_CLIENTS);
               state_d          = ISSUE;
            end
         end
         ISSUE: begin
            bus.dpi_req_valid  = 1'b1;
            bus.dpi_req_opcode = op_q;
            bus.dpi_req_len    = len_q;
            bus.dpi_req_addr   = addr_q;
            cnt_d              = CW'(len_q) + CW'(1);
            state_d            = (op_q == OP_WR) ? WDATA : RDATA;
         end
         WDATA: begin
            bus.cl_wr_ready[gnt_q] = 1'b1;
            bus.dpi_wr_valid       = bus.cl_wr_valid[gnt_q];
            bus.dpi_wr_bits        = bus.cl_wr_bits[gnt_q*DATA_BITS +: DATA_BITS];
            beat                   = bus.cl_wr_valid[gnt_q];
         end
         RDATA: begin
            bus.cl_rd_valid[gnt_q] = bus.dpi_rd_valid;
            bus.cl_rd_bits         = bus.dpi_rd_bits;
            bus.dpi_rd_ready       = bus.cl_rd_ready[gnt_q];
            beat                   = bus.dpi_rd_valid & bus.cl_rd_ready[gnt_q];
         end
         default: state_d = IDLE;
      endcase
      // counter is one bit wider than len, so a full 2^LEN_BITS burst ends exactly at 1
      if (beat) begin
         cnt_d   = cnt_q - CW'(1);
         state_d = (cnt_q == CW'(1)) ? IDLE : state_q;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         op_q    <= 1'b0;
         len_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         op_q    <= op_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy_o     = state_q != IDLE;
   assign grant_id_o = gnt_q;
endmodule

// File: tb/tb_vta_mem_arbiter.sv
// tb_vta_mem_arbiter: random and directed bursts through the arbiter, checked by a scoreboard monitor.
module tb_vta_mem_arbiter;
   import vta_mem_arb_pkg::*;
   localparam int N = 2, LB = 8, AB = 64, DB = 64;

   typedef struct {
      int          c;
      logic        op;
      int          len;
      logic [63:0] addr;
   } txn_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic busy;
   logic [0:0] gid;
   int errs = 0, checks = 0;

   txn_t plan[256];
   int   plan_n = 0;
   logic toggle_rd = 1'b0;

   txn_t m_cur;
   logic m_act = 1'b0;
   int   m_beats = 0, done_n = 0, rd0_beats = 0, wr0_cnt = 0;
   logic [63:0] last_wr = '0;
   int   gseq[$];

   vta_mem_arbiter_if #(.NUM_CLIENTS(N), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

   vta_mem_arbiter #(.NUM_CLIENTS(N), .LEN_BITS(LB), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
      .clk_i(clk), .rst_ni(rst_n), .bus(bus), .busy_o(busy), .grant_id_o(gid)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] wdata(logic [63:0] a, int b);
      return a ^ 64'hDEADBEEF ^ (64'(b) << 32);
   endfunction

   function automatic logic [63:0] rdata(logic [63:0] a, int b);
      return ~a + 64'(b) * 64'h9E3779B97F4A7C15;
   endfunction

   // round-robin from the client after the previous winner; client 0 first in the priority build
   function automatic int pick(logic [N-1:0] v, int last);
`ifdef MEM_ARB_PRIO_EN
      if (v[0]) return 0;
`endif
      for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
      return -1;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // client agents: issue plan entries in order, one outstanding transaction per client
   initial begin
      txn_t cur[N];
      logic pend[N], dact[N];
      int   beat[N], pi;
      logic tog;
      logic [N-1:0] rv, ov, wv, rr;
      logic [N*LB-1:0] lv;
      logic [N*AB-1:0] av;
      logic [N*DB-1:0] dv;
      pi = 0;
      tog = 1'b0;
      for (int c = 0; c < N; c++) begin pend[c] = 0; dact[c] = 0; beat[c] = 0; cur[c] = '{0, 1'b0, 0, '0}; end
      bus.cl_req_valid = '0; bus.cl_req_opcode = '0; bus.cl_req_len = '0; bus.cl_req_addr = '0;
      bus.cl_wr_valid = '0; bus.cl_wr_bits = '0; bus.cl_rd_ready = '0;
      forever begin
         @(negedge clk);
         for (int c = 0; c < N; c++) begin
            if (!rst_n) begin
               pend[c] = 0; dact[c] = 0;
            end else if (bus.cl_req_valid[c] && bus.cl_req_ready[c]) begin
               pend[c] = 0; dact[c] = 1; beat[c] = 0;
            end else if (dact[c] && (cur[c].op ? (bus.cl_wr_valid[c] && bus.cl_wr_ready[c])
                                               : (bus.cl_rd_valid[c] && bus.cl_rd_ready[c]))) begin
               beat[c]++;
               if (beat[c] == cur[c].len + 1) dact[c] = 0;
            end
         end
         @(posedge clk);
         #1;
         if (rst_n && pi < plan_n && !pend[plan[pi].c] && !dact[plan[pi].c]) begin
            cur[plan[pi].c] = plan[pi];
            pend[plan[pi].c] = 1;
            pi++;
         end
         tog = ~tog;
         for (int c = 0; c < N; c++) begin
            rv[c] = pend[c];
            ov[c] = cur[c].op;
            lv[c*LB +: LB] = LB'(cur[c].len);
            av[c*AB +: AB] = cur[c].addr;
            wv[c] = dact[c] && cur[c].op && ($urandom_range(3) != 0);
            dv[c*DB +: DB] = wdata(cur[c].addr, beat[c]);
            rr[c] = toggle_rd ? tog : ($urandom_range(3) != 0);
         end
         bus.cl_req_valid = rv; bus.cl_req_opcode = ov; bus.cl_req_len = lv; bus.cl_req_addr = av;
         bus.cl_wr_valid = wv; bus.cl_wr_bits = dv; bus.cl_rd_ready = rr;
      end
   end

   // DPI memory: serves read bursts with random bubbles
   initial begin
      logic act;
      logic [63:0] a;
      int len, b;
      act = 0; a = '0; len = 0; b = 0;
      bus.dpi_rd_valid = 1'b0;
      bus.dpi_rd_bits = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) act = 0;
         else begin
            if (act && bus.dpi_rd_valid && bus.dpi_rd_ready) begin
               b++;
               if (b == len + 1) act = 0;
            end
            if (bus.dpi_req_valid && bus.dpi_req_opcode == OP_RD) begin
               act = 1; a = bus.dpi_req_addr; len = int'(bus.dpi_req_len); b = 0;
            end
         end
         @(posedge clk);
         #1;
         bus.dpi_rd_valid = act && rst_n && ($urandom_range(3) != 0);
         bus.dpi_rd_bits = act ? rdata(a, b) : {$urandom, $urandom};
      end
   end

   // scoreboard monitor
   initial begin
      txn_t expq[$];
      logic iss_due, idle_due, was;
      int last, w;
      iss_due = 0; idle_due = 0; last = N - 1;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            expq.delete(); m_act = 0; iss_due = 0; idle_due = 0; last = N - 1;
            continue;
         end
         if (bus.cl_wr_ready[0]) wr0_cnt++;
         if (idle_due) begin chk("busy_after_last", 64'(busy), 0); idle_due = 0; end
         was = m_act;
         if (m_act) begin
            if (!busy) begin
               chk("early_end", 64'(m_beats), 64'(m_cur.len + 1));
               m_act = 0;
            end else if (m_cur.op) begin
               chk("wr_ready", 64'(bus.cl_wr_ready), 64'(1) << m_cur.c);
               chk("wr_valid_pass", 64'(bus.dpi_wr_valid), 64'(bus.cl_wr_valid[m_cur.c]));
               if (bus.dpi_wr_valid) begin
                  chk("wr_data", bus.dpi_wr_bits, wdata(m_cur.addr, m_beats));
                  last_wr = bus.dpi_wr_bits;
                  m_beats++;
               end
            end else begin
               chk("rd_valid", 64'(bus.cl_rd_valid), 64'(bus.dpi_rd_valid) << m_cur.c);
               chk("rd_ready_pass", 64'(bus.dpi_rd_ready), 64'(bus.cl_rd_ready[m_cur.c]));
               if (bus.dpi_rd_valid && bus.cl_rd_ready[m_cur.c]) begin
                  chk("rd_data", bus.cl_rd_bits, rdata(m_cur.addr, m_beats));
                  if (m_cur.c == 0) rd0_beats++;
                  m_beats++;
               end
            end
            if (m_act && m_beats == m_cur.len + 1) begin m_act = 0; idle_due = 1; done_n++; end
         end
         if (!was) chk("data_quiet", {60'd0, |bus.cl_wr_ready, |bus.cl_rd_valid, bus.dpi_wr_valid, bus.dpi_rd_ready}, 0);
         if (iss_due) begin
            iss_due = 0;
            chk("req_valid", 64'(bus.dpi_req_valid), 1);
            if (expq.size() > 0) begin
               m_cur = expq.pop_front();
               chk("req_op", 64'(bus.dpi_req_opcode), 64'(m_cur.op));
               chk("req_len", 64'(bus.dpi_req_len), 64'(m_cur.len));
               chk("req_addr", bus.dpi_req_addr, m_cur.addr);
               chk("grant_id", 64'(gid), 64'(m_cur.c));
               m_act = 1; m_beats = 0;
            end
         end else chk("req_quiet", 64'(bus.dpi_req_valid), 0);
         if (!busy && |bus.cl_req_valid) begin
            w = pick(bus.cl_req_valid, last);
            chk("grant", 64'(bus.cl_req_ready), 64'(1) << w);
            expq.push_back('{w, bus.cl_req_opcode[w], int'(bus.cl_req_len[w*LB +: LB]), bus.cl_req_addr[w*AB +: AB]});
            last = w; iss_due = 1; gseq.push_back(w);
         end else chk("ready_low", 64'(bus.cl_req_ready), 0);
      end
   end

   task automatic add(int c, logic op, int len, logic [63:0] addr);
      plan[plan_n] = '{c, op, len, addr};
      plan_n++;
   endtask

   task automatic wait_done(int tgt, int budget);
      int k;
      k = 0;
      while (done_n < tgt && k < budget) begin @(negedge clk); k++; end
      chk("done_count", 64'(done_n), 64'(tgt));
   endtask

   task automatic rst_chk(string tag);
      chk({tag, "_ctl"}, {53'd0, bus.dpi_req_valid, bus.dpi_req_opcode, bus.dpi_wr_valid, bus.dpi_rd_ready,
                          bus.cl_req_ready, bus.cl_wr_ready, bus.cl_rd_valid, busy, gid}, 0);
      chk({tag, "_len"}, 64'(bus.dpi_req_len), 0);
      chk({tag, "_addr"}, bus.dpi_req_addr, 0);
      chk({tag, "_wbits"}, bus.dpi_wr_bits, 0);
      chk({tag, "_rbits"}, bus.cl_rd_bits, 0);
   endtask

   initial begin
      int t, s, g0, k;
      int exp_seq[4];
`ifdef MEM_ARB_PRIO_EN
      exp_seq = '{0, 0, 1, 1};
`else
      exp_seq = '{0, 1, 0, 1};
`endif
      repeat (3) @(posedge clk);
      #1 rst_chk("reset");
      @(negedge clk) rst_n = 1'b1;
      s = rd0_beats; t = done_n + 1;
      add(0, OP_RD, 3, 64'h1000);
      wait_done(t, 200);
      chk("t1_beats", 64'(rd0_beats - s), 4);
      s = wr0_cnt; t = done_n + 1;
      add(1, OP_WR, 0, 64'h0);
      wait_done(t, 200);
      chk("t2_data", last_wr, 64'hDEADBEEF);
      chk("t2_wr_ready0", 64'(wr0_cnt - s), 0);
      g0 = gseq.size(); t = done_n + 4;
      add(0, OP_RD, 0, 64'h100); add(1, OP_RD, 0, 64'h200);
      add(0, OP_RD, 0, 64'h300); add(1, OP_RD, 0, 64'h400);
      wait_done(t, 400);
      for (int i = 0; i < 4; i++) chk("t3_seq", 64'(gseq.size() > g0 + i ? gseq[g0 + i] : -1), 64'(exp_seq[i]));
      toggle_rd = 1'b1; t = done_n + 1;
      add(0, OP_RD, 1, 64'h2000);
      wait_done(t, 200);
      toggle_rd = 1'b0; t = done_n + 1;
      add(0, OP_WR, 255, 64'h3000);
      wait_done(t, 3000);
      t = done_n + 40;
      for (int i = 0; i < 40; i++)
         add($urandom_range(N - 1), 1'($urandom_range(1)), ($urandom_range(3) == 0) ? 0 : $urandom_range(15), {$urandom, $urandom});
      wait_done(t, 8000);
      add(0, OP_RD, 7, 64'h4000);
      k = 0;
      while (!(m_act && !m_cur.op && m_beats >= 2) && k < 500) begin @(negedge clk); k++; end
      chk("t6_mid_burst", 64'(k < 500), 1);
      #2 rst_n = 1'b0;
      #1 rst_chk("mid_reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      t = done_n + 1;
      add(1, OP_RD, 0, 64'h5000);
      wait_done(t, 200);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
